// File: rtl/hazard_ctl.sv
`default_nettype none

`ifndef SIZE_SRC_GP
`define SIZE_SRC_GP 4
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_SRC_SR
`define SIZE_SRC_SR 2
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif

// ============================================================================
// Module      : hazard_ctl
// Description : Issue/hazard controller. Keeps a per-register scoreboard of
//               in-flight writes, stalls decode on data hazards, holds issue
//               while a branch resolves (with timeout), and flushes on taken.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctl #(
    parameter int WB_LAT = 3,
    parameter int BR_TMO = 7
) (
    input  logic                           iw_clk,
    input  logic                           iw_rst,
    input  logic                           iw_valid,
    input  logic                           iw_src_gp_rd,
    input  logic [`SIZE_SRC_GP-1:0]        iw_src_gp,
    input  logic                           iw_tgt_gp_rd,
    input  logic                           iw_tgt_gp_we,
    input  logic [`SIZE_TGT_GP-1:0]        iw_tgt_gp,
    input  logic                           iw_src_sr_rd,
    input  logic [`SIZE_SRC_SR-1:0]        iw_src_sr,
    input  logic                           iw_tgt_sr_we,
    input  logic [`SIZE_TGT_SR-1:0]        iw_tgt_sr,
    input  logic                           iw_is_branch,
    input  logic                           iw_br_done,
    input  logic                           iw_br_taken,
    output logic                           ow_issue,
    output logic                           ow_stall,
    output logic                           ow_flush,
    output logic                           ow_br_tmo,
    output logic [(1<<`SIZE_TGT_GP)-1:0]   ow_busy_gp,
    output logic [(1<<`SIZE_TGT_SR)-1:0]   ow_busy_sr
);

    localparam int         c_num_gp    = 1 << `SIZE_TGT_GP;
    localparam int         c_num_sr    = 1 << `SIZE_TGT_SR;
    localparam int         c_tgw       = `SIZE_TGT_GP;
    localparam int         c_tsw       = `SIZE_TGT_SR;
    localparam logic [1:0] c_load      = 2'(WB_LAT);
    // Last BR_WAIT cycle index; leaving on it gives exactly BR_TMO wait cycles
    localparam logic [3:0] c_wait_last = 4'(BR_TMO - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_wait_cnt;
    logic       r_br_tmo;
    logic       w_hazard;

    // GP scoreboard: one pending-write countdown per register
    generate
        for (genvar gi = 0; gi < c_num_gp; gi++) begin : g_gp_cnt
            logic [1:0] r_cnt;
            // Load on issued write to this register, else count down to zero
            always_ff @(posedge iw_clk) begin
                if (iw_rst) begin
                    r_cnt <= 2'd0;
                end else if (ow_issue && iw_tgt_gp_we && (iw_tgt_gp == c_tgw'(gi))) begin
                    r_cnt <= c_load;
                end else if (r_cnt != 2'd0) begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end
            assign ow_busy_gp[gi] = (r_cnt != 2'd0);
        end
    endgenerate

    // SR scoreboard: same behaviour as the GP file
    generate
        for (genvar si = 0; si < c_num_sr; si++) begin : g_sr_cnt
            logic [1:0] r_cnt;
            // Load on issued write to this register, else count down to zero
            always_ff @(posedge iw_clk) begin
                if (iw_rst) begin
                    r_cnt <= 2'd0;
                end else if (ow_issue && iw_tgt_sr_we && (iw_tgt_sr == c_tsw'(si))) begin
                    r_cnt <= c_load;
                end else if (r_cnt != 2'd0) begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end
            assign ow_busy_sr[si] = (r_cnt != 2'd0);
        end
    endgenerate

    // Any operand or destination still waiting on an in-flight write
    assign w_hazard = iw_valid &
                      ((iw_src_gp_rd & ow_busy_gp[iw_src_gp]) |
                       ((iw_tgt_gp_rd | iw_tgt_gp_we) & ow_busy_gp[iw_tgt_gp]) |
                       (iw_src_sr_rd & ow_busy_sr[iw_src_sr]) |
                       (iw_tgt_sr_we & ow_busy_sr[iw_tgt_sr]));

    // Issue only in RUN; BR_WAIT holds decode; FLUSH neither issues nor stalls
    assign ow_issue  = (r_state == ST_RUN) & iw_valid & ~w_hazard;
    assign ow_stall  = (r_state == ST_RUN) ? w_hazard : (r_state == ST_BR_WAIT);
    assign ow_flush  = (r_state == ST_FLUSH);
    assign ow_br_tmo = r_br_tmo;

    // Branch-control FSM with wait counter and registered timeout pulse
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 4'd0;
            r_br_tmo   <= 1'b0;
        end else begin
            r_br_tmo <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (ow_issue && iw_is_branch) begin
                        r_state    <= ST_BR_WAIT;
                        r_wait_cnt <= 4'd0;
                    end
                end
                ST_BR_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                    // A resolution on the final wait cycle beats the timeout
                    if (iw_br_done) begin
                        r_state <= iw_br_taken ? ST_FLUSH : ST_RUN;
                    end else if (r_wait_cnt == c_wait_last) begin
                        r_state  <= ST_RUN;
                        r_br_tmo <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctl.sv
`default_nettype none

`ifndef SIZE_SRC_GP
`define SIZE_SRC_GP 4
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_SRC_SR
`define SIZE_SRC_SR 2
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif

// ============================================================================
// Module      : tb_hazard_ctl
// Description : Self-checking bench for hazard_ctl. A timestamp-based model
//               (register ready cycle, branch issue cycle) predicts outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctl;

    localparam int WB_LAT = 3;
    localparam int BR_TMO = 7;
    localparam int NGP    = 1 << `SIZE_TGT_GP;
    localparam int NSR    = 1 << `SIZE_TGT_SR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, valid, src_gp_rd, tgt_gp_rd, tgt_gp_we;
    logic                     src_sr_rd, tgt_sr_we, is_branch, br_done, br_taken;
    logic [`SIZE_SRC_GP-1:0]  src_gp;
    logic [`SIZE_TGT_GP-1:0]  tgt_gp;
    logic [`SIZE_SRC_SR-1:0]  src_sr;
    logic [`SIZE_TGT_SR-1:0]  tgt_sr;
    logic                     issue, stall, flush, br_tmo;
    logic [NGP-1:0]           busy_gp;
    logic [NSR-1:0]           busy_sr;

    int checks = 0;
    int errors = 0;

    // Reference model: a register is busy while cycle < its ready cycle
    int  cyc;
    int  gp_ready [NGP];
    int  sr_ready [NSR];
    int  mode;          // 0 run, 1 waiting on branch, 2 flushing
    int  br_cyc;
    bit  m_tmo;
    logic last_issue;

    hazard_ctl #(.WB_LAT(WB_LAT), .BR_TMO(BR_TMO)) dut (
        .iw_clk       (clk),
        .iw_rst       (rst),
        .iw_valid     (valid),
        .iw_src_gp_rd (src_gp_rd),
        .iw_src_gp    (src_gp),
        .iw_tgt_gp_rd (tgt_gp_rd),
        .iw_tgt_gp_we (tgt_gp_we),
        .iw_tgt_gp    (tgt_gp),
        .iw_src_sr_rd (src_sr_rd),
        .iw_src_sr    (src_sr),
        .iw_tgt_sr_we (tgt_sr_we),
        .iw_tgt_sr    (tgt_sr),
        .iw_is_branch (is_branch),
        .iw_br_done   (br_done),
        .iw_br_taken  (br_taken),
        .ow_issue     (issue),
        .ow_stall     (stall),
        .ow_flush     (flush),
        .ow_br_tmo    (br_tmo),
        .ow_busy_gp   (busy_gp),
        .ow_busy_sr   (busy_sr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        valid = 0; src_gp_rd = 0; tgt_gp_rd = 0; tgt_gp_we = 0;
        src_sr_rd = 0; tgt_sr_we = 0; is_branch = 0; br_done = 0; br_taken = 0;
        src_gp = '0; tgt_gp = '0; src_sr = '0; tgt_sr = '0;
    endtask

    // One clock: predict, compare at negedge, advance model at posedge
    task automatic tick();
        logic [NGP-1:0] eg;
        logic [NSR-1:0] es;
        logic hz, ei, est, ef;
        for (int i = 0; i < NGP; i++) eg[i] = (cyc < gp_ready[i]);
        for (int i = 0; i < NSR; i++) es[i] = (cyc < sr_ready[i]);
        hz  = valid & ((src_gp_rd & eg[src_gp]) | ((tgt_gp_rd | tgt_gp_we) & eg[tgt_gp]) |
                       (src_sr_rd & es[src_sr]) | (tgt_sr_we & es[tgt_sr]));
        ei  = (mode == 0) & valid & ~hz;
        est = (mode == 0) ? hz : (mode == 1);
        ef  = (mode == 2);
        @(negedge clk);
        chk("busy_gp", 32'(busy_gp), 32'(eg));
        chk("busy_sr", 32'(busy_sr), 32'(es));
        chk("issue",   32'(issue),   32'(ei));
        chk("stall",   32'(stall),   32'(est));
        chk("flush",   32'(flush),   32'(ef));
        chk("br_tmo",  32'(br_tmo),  32'(m_tmo));
        last_issue = issue;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NGP; i++) gp_ready[i] = 0;
            for (int i = 0; i < NSR; i++) sr_ready[i] = 0;
            mode  = 0;
            m_tmo = 0;
        end else begin
            m_tmo = 0;
            if (ei && tgt_gp_we) gp_ready[tgt_gp] = cyc + WB_LAT + 1;
            if (ei && tgt_sr_we) sr_ready[tgt_sr] = cyc + WB_LAT + 1;
            case (mode)
                0: if (ei && is_branch) begin mode = 1; br_cyc = cyc; end
                1: begin
                    if (br_done) mode = br_taken ? 2 : 0;
                    else if (cyc - br_cyc == BR_TMO) begin mode = 0; m_tmo = 1; end
                end
                default: mode = 0;
            endcase
        end
        cyc++;
        #1;
    endtask

    task automatic hold_until_issue(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_issue && n < 12);
        checks++;
        assert (last_issue === 1'b1) else begin
            errors++;
            $error("FAIL %s_no_issue observed=%0b expected=1", tag, last_issue);
        end
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        cyc = 0; mode = 0; br_cyc = 0; m_tmo = 0; last_issue = 0;
        for (int i = 0; i < NGP; i++) gp_ready[i] = 0;
        for (int i = 0; i < NSR; i++) sr_ready[i] = 0;

        // Reset state with a bubble presented
        tick();

        // Write r3, then a reader of r3 held until it issues
        valid = 1; tgt_gp_we = 1; tgt_gp = 3;
        tick();
        idle(); valid = 1; src_gp_rd = 1; src_gp = 3;
        hold_until_issue("raw_r3");
        idle(); repeat (4) tick();

        // Independent back-to-back: r1 <- r2, r4 <- r5
        valid = 1; src_gp_rd = 1; src_gp = 2; tgt_gp_we = 1; tgt_gp = 1;
        tick();
        src_gp = 5; tgt_gp = 4;
        tick();
        idle(); repeat (4) tick();

        // Taken branch resolved two cycles after issue
        valid = 1; is_branch = 1;
        tick();
        idle(); tick();
        br_done = 1; br_taken = 1;
        tick();
        idle(); repeat (3) tick();

        // Not-taken branch; the held instruction issues right after
        valid = 1; is_branch = 1;
        tick();
        idle(); valid = 1; src_gp_rd = 1; src_gp = 7; br_done = 1; br_taken = 0;
        tick();
        br_done = 0;
        hold_until_issue("after_not_taken");
        idle(); repeat (2) tick();

        // Branch never resolved: timeout pulse
        valid = 1; is_branch = 1;
        tick();
        idle(); repeat (BR_TMO + 3) tick();

        // Reset while waiting on a branch with writes in flight
        valid = 1; tgt_gp_we = 1; tgt_gp = 6; tgt_sr_we = 1; tgt_sr = 1;
        tick();
        idle(); valid = 1; is_branch = 1;
        tick();
        idle(); tick();
        rst = 1;
        tick();
        rst = 0; valid = 1; src_gp_rd = 1; src_gp = 6;
        repeat (3) tick();
        idle(); tick();

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            valid     = ($urandom % 4) != 0;
            src_gp_rd = $urandom % 2;
            src_gp    = `SIZE_SRC_GP'($urandom);
            tgt_gp_rd = ($urandom % 4) == 0;
            tgt_gp_we = $urandom % 2;
            tgt_gp    = `SIZE_TGT_GP'($urandom);
            src_sr_rd = ($urandom % 3) == 0;
            src_sr    = `SIZE_SRC_SR'($urandom);
            tgt_sr_we = ($urandom % 3) == 0;
            tgt_sr    = `SIZE_TGT_SR'($urandom);
            is_branch = ($urandom % 6) == 0;
            br_done   = ($urandom % 5) == 0;
            br_taken  = $urandom % 2;
            tick();
        end

        idle();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
